pixel_write_unit: RTL and testbench

- Downstream stage of the render unit. It accepts a stream of (x, y, colour) pixel coordinates from the line/shape drawing logic and buffers them in a small FIFO.
- For each pixel it performs a read-modify-write into a 1-bpp 256x256 framebuffer held in a byte-wide synchronous single-port RAM.
- It also provides a whole-frame clear.
- Raising busy tells the render unit's controller that pixels are still in flight, so FinishWrite must not be signalled yet.

---
 rtl/pixel_write_unit_if.sv | 27 ++
 rtl/pixel_write_unit.sv | 165 ++++++++++++++++
 tb/tb_pixel_write_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_unit_if.sv
`timescale 1ns/1ps
// Pixel stream from the drawing logic plus the byte-wide framebuffer RAM port.
// The slave modport is the pixel write unit's view; master is the surrounding system.
interface pixel_write_unit_if #(
    parameter int FB_AW = 13
);
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       pix_x;
    logic [7:0]       pix_y;
    logic             pix_color;
    logic [FB_AW-1:0] fb_addr;
    logic             fb_rd_en;
    logic [7:0]       fb_rdata;
    logic             fb_wr_en;
    logic [7:0]       fb_wdata;

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, fb_rdata,
        input  pix_ready, fb_addr, fb_rd_en, fb_wr_en, fb_wdata
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, fb_rdata,
        output pix_ready, fb_addr, fb_rd_en, fb_wr_en, fb_wdata
    );
endinterface

// File: rtl/pixel_write_unit.sv
`timescale 1ns/1ps
// Buffers (x, y, colour) pixels and read-modify-writes them into a 1-bpp 256x256
// framebuffer held in a byte-wide single-port RAM; also performs whole-frame clears.
module pixel_write_unit #(
    parameter int FIFO_AW = 3,
    parameter int FB_AW   = 13
) (
    input  logic                     ACLK,
    input  logic                     reset,
    pixel_write_unit_if.slave        pix_fb,
    input  logic                     clear_req,
    input  logic                     clear_value,
    output logic                     busy,
    output logic [15:0]              pixels_written
);

    localparam int PW = 17;

    typedef enum logic [1:0] {IDLE, RD, WR, CLEAR} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      fifo_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, push, pop;
    logic               start_clear, clear_accept;
    logic               clear_pending, clear_val;
    logic [FB_AW-1:0]   clr_cnt;
    logic [7:0]         px_x, px_y;
    logic               px_color;
    logic [FB_AW-1:0]   px_addr;
    logic [FB_AW-1:0]   addr_o;
    logic               rd_en_o, wr_en_o;
    logic [7:0]         wdata_o;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] merge_bit(input logic [7:0] b, input logic [2:0] idx,
                                             input logic val);
        logic [7:0] r;
        r      = b;
        r[idx] = val;
        return r;
    endfunction

    // Count never exceeds the depth, so its MSB alone marks a full FIFO.
    assign full  = count[FIFO_AW];
    assign empty = (count == '0);

    assign pix_fb.pix_ready = !full && !reset;
    assign push             = pix_fb.pix_valid && pix_fb.pix_ready;
    assign clear_accept     = clear_req && !clear_pending && (state != CLEAR);
    assign px_addr          = {px_y, px_x[7:3]};

    always_ff @(posedge ACLK) begin
        if (push)
            fifo_mem[wr_ptr] <= {pix_fb.pix_color, pix_fb.pix_y, pix_fb.pix_x};
        if (pop)
            {px_color, px_y, px_x} <= fifo_mem[rd_ptr];
        if (clear_accept)
            clear_val <= clear_value;
    end

    always_ff @(posedge ACLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register and the counters it owns
    always_ff @(posedge ACLK) begin
        if (reset) begin
            state          <= IDLE;
            clear_pending  <= 1'b0;
            clr_cnt        <= '0;
            pixels_written <= 16'd0;
        end else begin
            state <= state_nxt;
            if (start_clear)
                clear_pending <= 1'b0;
            else if (clear_accept)
                clear_pending <= 1'b1;
            if (start_clear)
                clr_cnt <= '0;
            else if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            if (start_clear)
                pixels_written <= 16'd0;
            else if (state == WR)
                pixels_written <= sat_inc16(pixels_written);
        end
    end

    // Next state; a pending clear always wins over queued pixels
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        start_clear = 1'b0;
        case (state)
            IDLE, WR: begin
                if (clear_pending) begin
                    state_nxt   = CLEAR;
                    start_clear = 1'b1;
                end else if (!empty) begin
                    state_nxt = RD;
                    pop       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD:      state_nxt = WR;
            CLEAR:   if (clr_cnt == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes; held off during reset so an aborted operation issues no write
    always_comb begin
        addr_o  = '0;
        rd_en_o = 1'b0;
        wr_en_o = 1'b0;
        wdata_o = 8'h00;
        if (!reset) begin
            case (state)
                RD: begin
                    rd_en_o = 1'b1;
                    addr_o  = px_addr;
                end
                WR: begin
                    wr_en_o = 1'b1;
                    addr_o  = px_addr;
                    wdata_o = merge_bit(pix_fb.fb_rdata, px_x[2:0], px_color);
                end
                CLEAR: begin
                    wr_en_o = 1'b1;
                    addr_o  = clr_cnt;
                    wdata_o = {8{clear_val}};
                end
                default: ;
            endcase
        end
    end

    assign pix_fb.fb_addr  = addr_o;
    assign pix_fb.fb_rd_en = rd_en_o;
    assign pix_fb.fb_wr_en = wr_en_o;
    assign pix_fb.fb_wdata = wdata_o;

    assign busy = (state != IDLE) || !empty || clear_pending;

endmodule

// File: tb/tb_pixel_write_unit.sv
`timescale 1ns/1ps
// Bench for pixel_write_unit: a behavioural framebuffer RAM, a write scoreboard fed at
// push time, and a negedge monitor that checks every RAM write against it.
module tb_pixel_write_unit;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        ACLK = 1'b0;
    logic        reset = 1'b1;
    logic        clear_req = 1'b0;
    logic        clear_value = 1'b0;
    logic        busy;
    logic [15:0] pixels_written;

    logic        mem_clr = 1'b1;
    logic        poke_en = 1'b0;
    logic [12:0] poke_addr = '0;
    logic [7:0]  poke_data = '0;
    logic [7:0]  mem    [8192];
    logic [7:0]  ref_bm [8192];
    wr_t         exp_q  [$];

    int tests = 0;
    int fails = 0;

    pixel_write_unit_if #(.FB_AW(13)) bus ();

    pixel_write_unit #(.FIFO_AW(3), .FB_AW(13)) dut (
        .ACLK           (ACLK),
        .reset          (reset),
        .pix_fb         (bus),
        .clear_req      (clear_req),
        .clear_value    (clear_value),
        .busy           (busy),
        .pixels_written (pixels_written)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
        end else begin
            if (poke_en) mem[poke_addr] <= poke_data;
            if (bus.fb_wr_en) mem[bus.fb_addr] <= bus.fb_wdata;
            if (bus.fb_rd_en) bus.fb_rdata <= mem[bus.fb_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the oldest outstanding expectation
    always @(negedge ACLK) begin
        wr_t e;
        if (bus.fb_rd_en || bus.fb_wr_en)
            check("rd_wr_exclusive", 32'(bus.fb_rd_en && bus.fb_wr_en), 32'd0);
        if (bus.fb_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(bus.fb_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.fb_addr), 32'(e.addr));
                check("wr_data", 32'(bus.fb_wdata), 32'(e.data));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push_exp(input logic [7:0] x, input logic [7:0] y, input logic c,
                            input logic [12:0] ea, input logic [7:0] ed);
        bit ok;
        ok = 1'b0;
        bus.pix_x     = x;
        bus.pix_y     = y;
        bus.pix_color = c;
        bus.pix_valid = 1'b1;
        for (int n = 0; n < 10000 && !ok; n++) begin
            @(negedge ACLK);
            if (bus.pix_ready) ok = 1'b1;
            else begin
                @(posedge ACLK);
                #1;
            end
        end
        if (!ok) begin
            check("push_timeout", 32'd1, 32'd0);
            bus.pix_valid = 1'b0;
            return;
        end
        exp_q.push_back('{addr: ea, data: ed});
        ref_bm[ea] = ed;
        @(posedge ACLK);
        #1;
        bus.pix_valid = 1'b0;
    endtask

    task automatic push_rand(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [12:0] a;
        logic [7:0]  d;
        a       = {y, x[7:3]};
        d       = ref_bm[a];
        d[x[2:0]] = c;
        push_exp(x, y, c, a, d);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge ACLK);
            if (!busy) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
        @(posedge ACLK);
        #1;
    endtask

    logic [7:0] clr_px_exp [10] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
                                    8'hFE, 8'hFC};

    initial begin
        int          acc;
        bit          took;
        bit          hit;
        int          nbad;
        logic [7:0]  s100, s161, s8191;
        logic [7:0]  rx, ry;

        bus.pix_valid = 1'b0;
        bus.pix_x     = '0;
        bus.pix_y     = '0;
        bus.pix_color = 1'b0;
        for (int i = 0; i < 8192; i++) ref_bm[i] = 8'h00;

        // Reset
        repeat (3) @(posedge ACLK);
        #1 mem_clr = 1'b0;
        @(negedge ACLK);
        check("ready_in_reset", 32'(bus.pix_ready), 32'd0);
        @(posedge ACLK);
        #1 reset = 1'b0;
        @(negedge ACLK);
        check("rst_ready", 32'(bus.pix_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(bus.fb_rd_en), 32'd0);
        check("rst_wr_en", 32'(bus.fb_wr_en), 32'd0);
        check("rst_addr", 32'(bus.fb_addr), 32'd0);
        check("rst_wdata", 32'(bus.fb_wdata), 32'd0);
        check("rst_count", 32'(pixels_written), 32'd0);
        @(posedge ACLK);
        #1;

        // Single pixel (10,3,1): pop, RD, WR timing
        push_exp(8'd10, 8'd3, 1'b1, 13'd97, 8'h04);
        @(negedge ACLK);
        check("t1_no_rd_yet", 32'(bus.fb_rd_en), 32'd0);
        @(negedge ACLK);
        check("t1_rd_en", 32'(bus.fb_rd_en), 32'd1);
        check("t1_rd_addr", 32'(bus.fb_addr), 32'd97);
        @(negedge ACLK);
        check("t1_wr_en", 32'(bus.fb_wr_en), 32'd1);
        @(negedge ACLK);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_count", 32'(pixels_written), 32'd1);
        @(posedge ACLK);
        #1;

        // Back-to-back pixels in the same byte
        push_exp(8'd0, 8'd0, 1'b1, 13'd0, 8'h01);
        push_exp(8'd7, 8'd0, 1'b1, 13'd0, 8'h81);
        @(negedge ACLK);
        check("t2_rd1", 32'(bus.fb_rd_en), 32'd1);
        @(negedge ACLK);
        check("t2_wr1", 32'(bus.fb_wr_en), 32'd1);
        @(negedge ACLK);
        check("t2_rd2_follows", 32'(bus.fb_rd_en), 32'd1);
        @(negedge ACLK);
        check("t2_wr2", 32'(bus.fb_wr_en), 32'd1);
        check("t2_rdata2", 32'(bus.fb_rdata), 32'h01);
        wait_idle(50);

        // Clear a bit in a preloaded byte: (19,2) maps to byte 0x042, bit 3
        poke_en = 1'b1; poke_addr = 13'h042; poke_data = 8'hFF;
        @(posedge ACLK);
        #1 poke_en = 1'b0;
        ref_bm[13'h042] = 8'hFF;
        push_exp(8'd19, 8'd2, 1'b0, 13'h042, 8'hF7);
        @(negedge ACLK);
        @(negedge ACLK);
        check("t3_rd_en", 32'(bus.fb_rd_en), 32'd1);
        check("t3_rd_addr", 32'(bus.fb_addr), 32'h042);
        wait_idle(50);
        check("t3_count", 32'(pixels_written), 32'd4);

        // Full clear to 1 with pixels queued during it
        clear_value = 1'b1;
        clear_req   = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            exp_q.push_back('{addr: 13'(i), data: 8'hFF});
            ref_bm[i] = 8'hFF;
        end
        @(posedge ACLK);
        #1 clear_req = 1'b0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            if (acc < 10) begin
                bus.pix_x     = 8'(acc);
                bus.pix_y     = 8'd5;
                bus.pix_color = 1'b0;
                bus.pix_valid = 1'b1;
            end
            @(negedge ACLK);
            took = bus.pix_valid && bus.pix_ready;
            if (took) begin
                exp_q.push_back('{addr: (acc < 8) ? 13'd160 : 13'd161, data: clr_px_exp[acc]});
                acc++;
            end
            @(posedge ACLK);
            #1 bus.pix_valid = 1'b0;
        end
        check("t4_accepted", 32'(acc), 32'd8);
        @(negedge ACLK);
        check("t4_ready_low", 32'(bus.pix_ready), 32'd0);
        check("t4_count_zero", 32'(pixels_written), 32'd0);
        @(posedge ACLK);
        #1;
        push_exp(8'd8, 8'd5, 1'b0, 13'd161, clr_px_exp[8]);
        push_exp(8'd9, 8'd5, 1'b0, 13'd161, clr_px_exp[9]);
        ref_bm[160] = 8'h00;
        wait_idle(9000);
        check("t4_count", 32'(pixels_written), 32'd10);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while the clear is about to write address 100
        s100  = ref_bm[100];
        s161  = ref_bm[161];
        s8191 = ref_bm[8191];
        clear_value = 1'b0;
        clear_req   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back('{addr: 13'(i), data: 8'h00});
            ref_bm[i] = 8'h00;
        end
        @(posedge ACLK);
        #1 clear_req = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 400 && !hit; n++) begin
            @(negedge ACLK);
            if (bus.fb_wr_en && bus.fb_addr == 13'd99) hit = 1'b1;
        end
        check("t5_reached_99", 32'(hit), 32'd1);
        @(posedge ACLK);
        #1 reset = 1'b1;
        @(negedge ACLK);
        check("t5_no_wr_in_reset", 32'(bus.fb_wr_en), 32'd0);
        @(posedge ACLK);
        #1 reset = 1'b0;
        @(negedge ACLK);
        check("t5_rd_en", 32'(bus.fb_rd_en), 32'd0);
        check("t5_wr_en", 32'(bus.fb_wr_en), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(bus.pix_ready), 32'd1);
        check("t5_count", 32'(pixels_written), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t5_mem99", 32'(mem[99]), 32'h00);
        check("t5_mem100", 32'(mem[100]), 32'(s100));
        check("t5_mem161", 32'(mem[161]), 32'(s161));
        check("t5_mem8191", 32'(mem[8191]), 32'(s8191));
        @(posedge ACLK);
        #1;

        // Random stream of 1000 pixels with gaps
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            push_rand(rx, ry, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge ACLK);
                #1;
            end
        end
        wait_idle(5000);
        check("t6_count", 32'(pixels_written), 32'd1000);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        nbad = 0;
        for (int i = 0; i < 8192; i++)
            if (mem[i] !== ref_bm[i]) nbad++;
        check("t6_bitmap_mismatches", 32'(nbad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
